conv_fft_sched: RTL and testbench
=================================

Name: conv_fft_sched

Overview:
- Control sequencer for the FFT image-transform datapath: 4x fft4_2d feeding 4 image memory blocks.
- Owns one context: accepts ctx_length input cachelines, pulses FFT next per beat, writes each FFT result to consecutive memory addresses, then streams every address back out with valid/ready backpressure.
- Sits between the host cacheline interface and the memBlockImage bank; the datapath carries no control of its own.

Parameters:
- ADDR_W, 13, memory address width (depth 2^ADDR_W = 8192 tiles).
- RD_LAT, 1, memory read latency in cycles from mem_raddr to mem_rdata.
- DATA_W, 512, cacheline width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches ctx_length, begins context
- ctx_length  in  32  number of tiles/cachelines in context
- in_valid  in  1  input cacheline valid
- in_ready  out  1  controller accepts input beat
- fft_next  out  1  to all 4 fft4_2d next; asserted on each accepted beat
- fft_next_out  in  1  AND of the 4 fft4_2d next_out
- mem_we  out  1  image memory write enable
- mem_waddr  out  ADDR_W  image memory write address
- mem_raddr  out  ADDR_W  image memory read address
- mem_rdata  in  DATA_W  repacked memory read data
- out_valid  out  1  output cacheline valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_W  output cacheline
- busy  out  1  context in progress
- done  out  1  one-cycle pulse at context end
- err  out  1  sticky error flag; cleared by reset or next accepted start

Behaviour:
- Reset: state IDLE; in_ready, fft_next, mem_we, out_valid, busy, done, err = 0; addresses, counters, and skid FIFO cleared. Reset mid-context aborts immediately; no further we or out_valid.
- FSM states: IDLE, LOAD, DRAIN, READ, FLUSH, DONE.
- IDLE:
  - start with ctx_length==0 -> DONE.
  - start with ctx_length > 2^ADDR_W -> set err, -> DONE.
  - Otherwise latch len, clear counters, -> LOAD.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready = (issued < len).
  - On in_valid&in_ready: fft_next=1 in the same cycle (combinational), issued++.
  - issued==len -> DRAIN.
- LOAD/DRAIN write path: every fft_next_out cycle drives mem_we=1 combinationally, with mem_waddr = written, then written++.
- fft_next_out with written==issued (no tile outstanding): set err, no write.
- DRAIN: written==len -> READ.
- READ:
  - Issue read at mem_raddr=rd_issued when rd_issued<len and (in-flight + FIFO occupancy) < RD_LAT+1.
  - Data returns RD_LAT cycles later into a skid FIFO of depth RD_LAT+1; out_valid = FIFO non-empty, out_data = FIFO head.
  - Pop on out_valid&out_ready.
  - rd_issued==len -> FLUSH.
- FLUSH: wait until all len beats popped -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- busy = state not IDLE.
- No overflow: credit rule guarantees FIFO never overflows. Output order equals write order; exactly len out beats per context.
- Counters are ADDR_W+1 bits so len==2^ADDR_W fits; addresses use the low ADDR_W bits.
- Steady state with out_ready held high sustains one out beat per cycle.

Decomposition:
- Shared package conv_fft_pkg: state enum, ADDR_W/RD_LAT defaults, MEM_DEPTH constant.
- One sub-module, conv_fft_skid_fifo: parameterized depth RD_LAT+1, push/pop/count.
- FSM and counters stay in conv_fft_sched.

Test Plan:
- Nominal: start, len=4, in_valid held high, FFT model latency 6 -> fft_next 4 cycles; mem_we at waddr 0..3; 4 out beats matching written data in order; done pulse; err=0.
- Backpressure: len=8, out_ready toggled 1,0,0,1 pattern -> no lost or duplicated beat; FIFO count never exceeds 2; all 8 emitted in order.
- Boundaries:
  - len=0 -> done one cycle after start, no we, no out_valid.
  - len=8193 -> err=1, done, no activity.
  - len=8192 -> waddr reaches 8191, exactly 8192 out beats.
- Input stalls: in_valid 50% random, len=16 -> fft_next only on accepted beats; in_ready drops after 16th beat.
- Spurious fft_next_out with no tile outstanding -> err set, mem_we stays 0.
- Reset asserted mid-READ -> next cycle out_valid=0, busy=0; fresh start completes normally with err cleared.

Source files
------------

// File: rtl/conv_fft_sched_pkg.sv
// conv_fft_pkg: shared sizing and sequencer states for the FFT image-transform controller
package conv_fft_pkg;
  localparam int DEF_ADDR_W = 13;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_DATA_W = 512;
  localparam int MEM_DEPTH = 1 << DEF_ADDR_W;
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, READ, FLUSH, DONE} state_e;
endpackage

// File: rtl/conv_fft_sched_if.sv
// conv_fft_sched_if: host stream, fft array handshake and image memory port of the sequencer
interface conv_fft_sched_if
  import conv_fft_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic start;
  logic [31:0] ctx_length;
  logic in_valid, in_ready, fft_next, fft_next_out, mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_rdata, out_data;
  logic out_valid, out_ready, busy, done, err;
  modport master (
    input start, ctx_length, in_valid, fft_next_out, mem_rdata, out_ready,
    output in_ready, fft_next, mem_we, mem_waddr, mem_raddr, out_valid, out_data, busy, done, err
  );
  modport slave (
    output start, ctx_length, in_valid, fft_next_out, mem_rdata, out_ready,
    input in_ready, fft_next, mem_we, mem_waddr, mem_raddr, out_valid, out_data, busy, done, err
  );
endinterface

// File: rtl/conv_fft_sched_skid_fifo.sv
// conv_fft_skid_fifo: small skid buffer catching memory read data already in flight
module conv_fft_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 512,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int QW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [QW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [QW-1:0] cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d = push ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d = pop ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    cnt_d = cnt_q + QW'(push) - QW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/conv_fft_sched.sv
// conv_fft_sched: one-context sequencer feeding the fft4_2d array, filling image memory and streaming it back
module conv_fft_sched
  import conv_fft_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic clk,
  input logic reset,
  conv_fft_sched_if.master bus
);
  localparam int CW = ADDR_W + 1;
  localparam int DEPTH = RD_LAT + 1;
  localparam int QW = $clog2(DEPTH + 1);
  localparam logic [32:0] MAX_LEN = 33'(1) << ADDR_W;
  state_e state_q, state_d;
  logic [CW-1:0] len_q, len_d, issued_q, issued_d, written_q, written_d;
  logic [CW-1:0] rd_issued_q, rd_issued_d, popped_q, popped_d;
  logic err_q, err_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic [QW-1:0] fifo_cnt, inflight;
  logic [DATA_W-1:0] head;
  logic accept, wr, wr_phase, issue, pop;
  conv_fft_skid_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_fifo (
    .clk(clk), .reset(reset), .push(pipe_q[RD_LAT-1]), .din(bus.mem_rdata),
    .pop(pop), .dout(head), .count(fifo_cnt)
  );
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + QW'(pipe_q[i]);
  end
  assign bus.in_ready = state_q == LOAD && issued_q < len_q;
  assign accept = bus.in_ready && bus.in_valid;
  assign wr_phase = state_q == LOAD || state_q == DRAIN;
  assign wr = wr_phase && bus.fft_next_out && written_q != issued_q;
  assign bus.out_valid = fifo_cnt != '0;
  assign pop = bus.out_valid && bus.out_ready;
  // a slot popped this cycle is already free, so back-to-back reads keep one beat per cycle
  assign issue = state_q == READ && rd_issued_q < len_q
                 && CW'(inflight) + CW'(fifo_cnt) - CW'(pop) < CW'(DEPTH);
  assign bus.fft_next = accept;
  assign bus.mem_we = wr;
  assign bus.mem_waddr = written_q[ADDR_W-1:0];
  assign bus.mem_raddr = rd_issued_q[ADDR_W-1:0];
  assign bus.out_data = head;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.err = err_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    issued_d = issued_q + CW'(accept);
    written_d = written_q + CW'(wr);
    rd_issued_d = rd_issued_q + CW'(issue);
    popped_d = popped_q + CW'(pop);
    err_d = err_q || (wr_phase && bus.fft_next_out && written_q == issued_q);
    pipe_d = (pipe_q << 1) | RD_LAT'(issue);
    case (state_q)
      IDLE: if (bus.start) begin
        err_d = {1'b0, bus.ctx_length} > MAX_LEN;
        len_d = CW'(bus.ctx_length);
        issued_d = '0;
        written_d = '0;
        rd_issued_d = '0;
        popped_d = '0;
        state_d = (bus.ctx_length == 32'd0 || err_d) ? DONE : LOAD;
      end
      LOAD: state_d = issued_q == len_q ? DRAIN : LOAD;
      DRAIN: state_d = written_q == len_q ? READ : DRAIN;
      READ: state_d = rd_issued_q == len_q ? FLUSH : READ;
      FLUSH: state_d = popped_q == len_q ? DONE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q <= '0;
      issued_q <= '0;
      written_q <= '0;
      rd_issued_q <= '0;
      popped_q <= '0;
      err_q <= 1'b0;
      pipe_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      issued_q <= issued_d;
      written_q <= written_d;
      rd_issued_q <= rd_issued_d;
      popped_q <= popped_d;
      err_q <= err_d;
      pipe_q <= pipe_d;
    end
  end
endmodule

// File: tb/tb_conv_fft_sched.sv
// tb_conv_fft_sched: directed contexts against a latency-6 FFT model and a one-cycle image memory
module tb_conv_fft_sched;
  import conv_fft_pkg::*;
  localparam int FFT_LAT = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  conv_fft_sched_if bus ();
  conv_fft_sched u_dut (.clk(clk), .reset(reset), .bus(bus));
  logic [FFT_LAT-1:0] fv_q = '0;
  logic [31:0] ft_q [FFT_LAT];
  logic [31:0] ntag = '0;
  logic [31:0] seed = '0;
  logic spur = 1'b0;
  logic [DEF_DATA_W-1:0] mem [MEM_DEPTH];
  assign bus.fft_next_out = fv_q[FFT_LAT-1] | spur;
  always @(posedge clk) begin
    fv_q <= {fv_q[FFT_LAT-2:0], bus.fft_next};
    ft_q[0] <= seed + ntag;
    for (int i = 1; i < FFT_LAT; i++) ft_q[i] <= ft_q[i-1];
    ntag <= bus.start ? 32'd0 : ntag + 32'(bus.fft_next);
    if (bus.mem_we) mem[bus.mem_waddr] <= ~{16{ft_q[FFT_LAT-1]}};
    bus.mem_rdata <= mem[bus.mem_raddr];
  end
  int checks = 0, failures = 0;
  int n_nxt, n_bad_nxt, n_we, n_wa_err, max_wa, n_out, n_data_err, n_done, n_ir_err;
  int n_spur_we, fmax, first_out, last_out, done_cyc;
  logic err_end;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run_ctx(input int len, input int omode, input int imode, input int abort_at);
    int acc = 0;
    {n_nxt, n_bad_nxt, n_we, n_wa_err, n_out, n_data_err, n_done, n_ir_err, n_spur_we, fmax} = '0;
    max_wa = -1;
    first_out = -1;
    last_out = -1;
    done_cyc = -1;
    seed = 32'(len) * 32'h0101_0101 ^ 32'hC0DE_0000;
    @(posedge clk);
    #1 bus.start = 1'b1;
    bus.ctx_length = 32'(len);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int cyc = 0; cyc < 40000; cyc++) begin
      bus.in_valid = imode == 1 ? 1'($urandom_range(1)) : (imode == 2 ? 1'(cyc >= 3) : 1'b1);
      spur = imode == 2 && cyc == 1;
      bus.out_ready = omode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : omode != 2;
      @(negedge clk);
      if (bus.in_ready && acc >= len) n_ir_err++;
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.fft_next) n_nxt++;
      if (bus.fft_next != (bus.in_valid && bus.in_ready)) n_bad_nxt++;
      if (spur && bus.mem_we) n_spur_we++;
      if (bus.mem_we) begin
        if (bus.mem_waddr != 13'(n_we)) n_wa_err++;
        max_wa = int'(bus.mem_waddr);
        n_we++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (bus.out_data != ~{16{seed + 32'(n_out)}}) n_data_err++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        n_out++;
      end
      if (int'(u_dut.u_fifo.count) > fmax) fmax = int'(u_dut.u_fifo.count);
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0 || cyc == abort_at) break;
    end
    spur = 1'b0;
    bus.in_valid = 1'b0;
    err_end = bus.err;
  endtask
  task automatic check_ctx(input string t, input int beats, input logic exp_err);
    chk({t, ".done"}, n_done, 1);
    chk({t, ".fft_next"}, n_nxt, beats);
    chk({t, ".next_vs_accept"}, n_bad_nxt, 0);
    chk({t, ".we"}, n_we, beats);
    chk({t, ".waddr_seq"}, n_wa_err, 0);
    chk({t, ".out_beats"}, n_out, beats);
    chk({t, ".out_data"}, n_data_err, 0);
    chk({t, ".in_ready_after_len"}, n_ir_err, 0);
    chk({t, ".err"}, err_end, exp_err);
    chk({t, ".idle_after"}, {bus.busy, bus.done}, 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.ctx_length = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", {bus.in_ready, bus.fft_next, bus.mem_we, bus.out_valid, bus.busy, bus.done, bus.err}, 0);
    reset = 1'b0;
    run_ctx(4, 0, 0, -1);
    check_ctx("nominal", 4, 1'b0);
    chk("nominal.max_waddr", max_wa, 3);
    run_ctx(8193, 0, 0, -1);
    check_ctx("too_long", 0, 1'b1);
    chk("too_long.done_cycle", done_cyc, 0);
    run_ctx(4, 0, 0, -1);
    check_ctx("err_cleared", 4, 1'b0);
    run_ctx(0, 0, 0, -1);
    check_ctx("len0", 0, 1'b0);
    chk("len0.done_cycle", done_cyc, 0);
    run_ctx(8, 1, 0, -1);
    check_ctx("backpressure", 8, 1'b0);
    chk("backpressure.fifo_max_le2", fmax <= 2, 1);
    run_ctx(16, 0, 1, -1);
    check_ctx("in_stall", 16, 1'b0);
    run_ctx(4, 0, 2, -1);
    check_ctx("spurious", 4, 1'b1);
    chk("spurious.no_we", n_spur_we, 0);
    run_ctx(8, 2, 0, 20);
    chk("mid_read.out_valid_before", bus.out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_read.after_reset", {bus.out_valid, bus.busy, bus.mem_we, bus.err}, 0);
    reset = 1'b0;
    run_ctx(4, 0, 0, -1);
    check_ctx("after_abort", 4, 1'b0);
    run_ctx(8192, 0, 0, -1);
    check_ctx("full_depth", 8192, 1'b0);
    chk("full_depth.max_waddr", max_wa, 8191);
    chk("full_depth.one_beat_per_cycle", last_out - first_out, 8191);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
